// File: rtl/seg_scan_ctrl.sv
// Scan controller for the shared seven-segment bus. Each digit slot is BLANK_CYCLES dark, then a SHOW phase; the inputs are snapshotted once per frame.
// Every output is registered and moves on the same edge as the FSM. The scan is free-running and has no backpressure.
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   digit_en,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                lz_en,
  output logic [6:0]          SEG,
  output logic                DP,
  output logic [DIGITS-1:0]   AN,
  output logic                frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_nxt;

  logic [DIGITS-1:0][3:0] r_val_s;
  logic [DIGITS-1:0][3:0] w_val_nxt;
  logic [DIGITS-1:0]      r_en_s;
  logic [DIGITS-1:0]      w_en_nxt;
  logic [DIGITS-1:0]      r_dp_s;
  logic [DIGITS-1:0]      w_dp_nxt;
  logic                   r_lz_s;
  logic                   w_lz_nxt;
  logic                   w_snap;

  logic [DIGITS-1:0]      w_sup;
  logic                   w_zero_above;
  logic                   w_lit;
  logic [3:0]             w_nib;
  logic [DIGITS-1:0]      w_an_nxt;
  logic [6:0]             w_seg_nxt;
  logic                   w_dpo_nxt;

  logic [DIGITS-1:0]      r_an;
  logic [6:0]             r_seg;
  logic                   r_dpo;
  logic                   r_tick;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_BLANK;
      end
    endcase
  end

  // The display is driven from post-edge snapshot values, so a snapshot edge that goes straight to SHOW still shows fresh data.
  assign w_snap    = (r_state == ST_BLANK) && (r_idx == '0) && (r_cnt == '0);
  assign w_val_nxt = w_snap ? value    : r_val_s;
  assign w_en_nxt  = w_snap ? digit_en : r_en_s;
  assign w_dp_nxt  = w_snap ? dp_in    : r_dp_s;
  assign w_lz_nxt  = w_snap ? lz_en    : r_lz_s;

  // Walk down from the top digit: a digit stays blank while every enabled nibble at or above it is zero.
  always_comb begin
    w_sup        = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero_above = w_zero_above & (~w_en_nxt[i] | (w_val_nxt[i] == 4'd0));
      w_sup[i]     = w_lz_nxt & w_zero_above;
    end
  end

  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = 7'b1111111;
    w_dpo_nxt = 1'b1;
    w_nib     = w_val_nxt[w_idx_nxt];
    w_lit     = (w_state_nxt == ST_SHOW) && w_en_nxt[w_idx_nxt] && !w_sup[w_idx_nxt];
    if (w_state_nxt == ST_SHOW) begin
      w_seg_nxt = hex_decode(w_nib);
    end
    if (w_lit) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
      w_dpo_nxt           = ~w_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_val_s <= '0;
      r_en_s  <= '0;
      r_dp_s  <= '0;
      r_lz_s  <= 1'b0;
      r_an    <= '1;
      r_seg   <= 7'b1111111;
      r_dpo   <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_val_s <= w_val_nxt;
      r_en_s  <= w_en_nxt;
      r_dp_s  <= w_dp_nxt;
      r_lz_s  <= w_lz_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dpo   <= w_dpo_nxt;
      r_tick  <= w_snap;
    end
  end

  assign AN         = r_an;
  assign SEG        = r_seg;
  assign DP         = r_dpo;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl. A time-based frame model pushes the expected outputs for every cycle into a queue.
// A separate monitor pops each entry on the falling edge and compares it with the DUT.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 8;
  localparam int PRESCALE = 8;
  localparam int BLANK = 2;
  localparam int FRAME = DIGITS * PRESCALE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = 32'h0000_00A5;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  dp_in = 8'h00;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t q[$];

  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .value     (value),
    .digit_en  (digit_en),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .SEG       (seg),
    .DP        (dp),
    .AN        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the position within the frame comes from edges counted since reset release.
  logic [31:0] s_val;
  logic [7:0]  s_en;
  logic [7:0]  s_dp;
  logic        s_lz;
  int          k;

  function automatic bit suppressed(input int d);
    if (!s_lz || d == 0) return 1'b0;
    for (int j = d; j < DIGITS; j++)
      if (s_en[j] && (s_val[4*j +: 4] != 4'd0)) return 1'b0;
    return 1'b1;
  endfunction

  initial begin : model
    exp_t e;
    int   pos;
    int   slot;
    bit   lit;
    k = 0;
    forever begin
      @(posedge clk);
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
      if (!rst_n) begin
        k = 0;
      end else begin
        k++;
        pos = k % FRAME;
        if (pos == 1) begin
          s_val = value;
          s_en  = digit_en;
          s_dp  = dp_in;
          s_lz  = lz_en;
          e.tick = 1'b1;
        end
        slot = pos / PRESCALE;
        if ((pos % PRESCALE) >= BLANK) begin
          lit   = s_en[slot] && !suppressed(slot);
          e.seg = dec[s_val[4*slot +: 4]];
          if (lit) begin
            e.an = ~(8'b1 << slot);
            e.dp = ~s_dp[slot];
          end
        end
      end
      q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        check("queue_nonempty", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        check("AN", {24'd0, an}, {24'd0, e.an});
        check("SEG", {25'd0, seg}, {25'd0, e.seg});
        check("DP", {31'd0, dp}, {31'd0, e.dp});
        check("frame_tick", {31'd0, frame_tick}, {31'd0, e.tick});
      end
      check("AN_onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    check("frame_tick_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic drive(input logic [31:0] v, input logic [7:0] en, input logic [7:0] d, input logic lz);
    @(negedge clk);
    #2;
    value    = v;
    digit_en = en;
    dp_in    = d;
    lz_en    = lz;
  endtask

  initial begin : stim
    logic [31:0] rv;
    cycles(3);
    #2 rst_n = 1'b1;
    cycles(2 * FRAME);

    drive(32'h0000_00A5, 8'hFF, 8'h00, 1'b1);
    cycles(2 * FRAME);
    drive(32'h0000_0000, 8'hFF, 8'h00, 1'b1);
    cycles(2 * FRAME);
    drive(32'h1234_5678, 8'h0F, 8'h00, 1'b0);
    cycles(2 * FRAME);

    // Change the data during SHOW of slot 3: the rest of this frame keeps the old snapshot.
    wait_tick();
    cycles(3 * PRESCALE + 2);
    #2;
    value    = 32'hFFFF_FFFF;
    digit_en = 8'hFF;
    cycles(2 * FRAME);

    drive(32'hFFFF_FFFF, 8'hFF, 8'h04, 1'b0);
    cycles(2 * FRAME);

    // Assert reset asynchronously during SHOW of slot 5.
    wait_tick();
    cycles(5 * PRESCALE + 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_AN", {24'd0, an}, 32'h0000_00FF);
    check("rst_async_SEG", {25'd0, seg}, 32'h0000_007F);
    check("rst_async_DP", {31'd0, dp}, 32'd1);
    check("rst_async_tick", {31'd0, frame_tick}, 32'd0);
    cycles(2);
    #2 rst_n = 1'b1;
    cycles(2 * FRAME);

    for (int it = 0; it < 30; it++) begin
      rv = '0;
      for (int n = 0; n < DIGITS; n++)
        if ($urandom_range(0, 1) == 1) rv[4*n +: 4] = 4'($urandom_range(1, 15));
      drive(rv, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
      cycles($urandom_range(1, 100));
    end

    cycles(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
